quadrant_selector: RTL

//  Upstream control stage of the VGA display path. Debounces three board keys and lets the user pick one
//  of 16 image quadrants (1..16, row-major, 4x4 over the 400x400 window). Launches processing of the

---
 rtl/quadrant_selector_if.sv | 23 ++
 rtl/quadrant_selector.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/quadrant_selector_if.sv
// Key/processor handshake bundle between the quadrant selector and its neighbours.
// The slave modport is the selector's view; the master modport belongs to whoever drives the keys and proc_done.
interface quadrant_selector_if;
  logic       key_next_n;
  logic       key_prev_n;
  logic       key_start_n;
  logic       proc_done;
  logic [4:0] quadrant;
  logic       start_proc;
  logic       show_result;
  logic       busy;
  logic       err;

  modport slave (
    input  key_next_n, key_prev_n, key_start_n, proc_done,
    output quadrant, start_proc, show_result, busy, err
  );

  modport master (
    output key_next_n, key_prev_n, key_start_n, proc_done,
    input  quadrant, start_proc, show_result, busy, err
  );
endinterface

// File: rtl/quadrant_selector.sv
// Key debounce and quadrant-select / run / show control for the VGA display path.
// Optional RUN-state watchdog enabled by defining RUN_TIMEOUT_EN.

// One key: 2-FF synchroniser, stability counter, one-cycle press pulse.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_pipe;
  logic          deb_n;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_pipe <= 2'b11;
      deb_n     <= 1'b1;
      cnt       <= '0;
      press     <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[0], key_n};
      press     <= 1'b0;
      if (sync_pipe[1] == deb_n) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        // Accept the new level; only the falling (press) direction yields an event.
        deb_n <= sync_pipe[1];
        cnt   <= '0;
        press <= ~sync_pipe[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module quadrant_selector #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TIMEOUT_CYCLES  = 2**24
) (
  input  logic              clk,
  input  logic              rst_n,
  quadrant_selector_if.slave bus
);
  localparam int NUM_KEYS = 3;
  localparam int K_NEXT   = 0;
  localparam int K_PREV   = 1;
  localparam int K_START  = 2;

  typedef enum logic [1:0] {S_SELECT, S_RUN, S_SHOW} state_t;

  logic [NUM_KEYS-1:0] keys_n;
  logic [NUM_KEYS-1:0] press;

  assign keys_n[K_NEXT]  = bus.key_next_n;
  assign keys_n[K_PREV]  = bus.key_prev_n;
  assign keys_n[K_START] = bus.key_start_n;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .key_n (keys_n[k]),
      .press (press[k])
    );
  end

  state_t     state_q, state_d;
  logic [4:0] quad_q, quad_d;
  logic       start_q, start_d;
  logic       show_q, show_d;
  logic       busy_q, busy_d;

`ifdef RUN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = |TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_SELECT;
      quad_q  <= 5'd1;
      start_q <= 1'b0;
      show_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef RUN_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      quad_q  <= quad_d;
      start_q <= start_d;
      show_q  <= show_d;
      busy_q  <= busy_d;
`ifdef RUN_TIMEOUT_EN
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    quad_d  = quad_q;
    start_d = 1'b0;
`ifdef RUN_TIMEOUT_EN
    tmo_d   = '0;
    err_d   = err_q;
`endif
    unique case (state_q)
      S_SELECT: begin
        // start outranks a same-cycle next/prev; next+prev together cancel.
        if (press[K_START]) begin
          state_d = S_RUN;
          start_d = 1'b1;
        end else if (press[K_NEXT] && !press[K_PREV]) begin
          quad_d = (quad_q == 5'd16) ? 5'd1 : quad_q + 5'd1;
        end else if (press[K_PREV] && !press[K_NEXT]) begin
          quad_d = (quad_q == 5'd1) ? 5'd16 : quad_q - 5'd1;
        end
      end
      S_RUN: begin
        if (bus.proc_done) begin
          state_d = S_SHOW;
`ifdef RUN_TIMEOUT_EN
        end else if (tmo_q == TMO_MAX) begin
          state_d = S_SELECT;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
`endif
        end
      end
      S_SHOW: begin
        if (press[K_START]) state_d = S_SELECT;
      end
      default: state_d = S_SELECT;
    endcase
    busy_d = (state_d == S_RUN);
    show_d = (state_d == S_SHOW);
  end

  assign bus.quadrant    = quad_q;
  assign bus.start_proc  = start_q;
  assign bus.show_result = show_q;
  assign bus.busy        = busy_q;
`ifdef RUN_TIMEOUT_EN
  assign bus.err         = err_q;
`else
  assign bus.err         = 1'b0;
`endif
endmodule
